// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, computes the result at issue and holds it
// in temporaries while a down-counter models the multi-cycle latency.
module md_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYC);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

    // Full 64-bit product; sign-extending to 64 bits makes the low 64 bits exact for both signednesses.
    function automatic logic [63:0] mul_res(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {{32{sgn & x[31]}}, x};
        ye = {{32{sgn & y[31]}}, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes then restores signs.
    function automatic logic [63:0] div_res(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg_q;
        logic        neg_r;
        neg_r = sgn & x[31];
        neg_q = sgn & (x[31] ^ y[31]);
        xm = neg_r ? (32'd0 - x) : x;
        ym = (sgn & y[31]) ? (32'd0 - y) : y;
        if (ym == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = xm / ym;
            r = xm % ym;
        end
        if (neg_q) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_r) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [31:0] temp_hi_r;
    logic [31:0] temp_lo_r;
    logic [31:0] temp_hi_nxt_s;
    logic [31:0] temp_lo_nxt_s;
    logic        dz_r;
    logic        dz_nxt_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;
    logic        busy_r;
    logic [63:0] mul_s;
    logic [63:0] div_s;

    assign mul_s = mul_res(a, b, ~md_op[0]);
    assign div_s = div_res(a, b, ~md_op[0]);

    // Next-state logic: issue in IDLE, count down in RUN, commit on the 1->0 step.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        temp_hi_nxt_s = temp_hi_r;
        temp_lo_nxt_s = temp_lo_r;
        dz_nxt_s      = dz_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        if (cnt_r == 4'd0) begin
            if (start) begin
                case (md_op)
                    3'd0, 3'd1: begin
                        temp_hi_nxt_s = mul_s[63:32];
                        temp_lo_nxt_s = mul_s[31:0];
                        dz_nxt_s      = 1'b0;
                        cnt_nxt_s     = MULT_N;
                    end
                    3'd2, 3'd3: begin
                        temp_hi_nxt_s = div_s[63:32];
                        temp_lo_nxt_s = div_s[31:0];
                        dz_nxt_s      = (b == 32'd0);
                        cnt_nxt_s     = DIV_N;
                    end
                    3'd4:    hi_nxt_s = a;
                    3'd5:    lo_nxt_s = a;
                    default: cnt_nxt_s = cnt_r;
                endcase
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            cnt_nxt_s = cnt_r - 4'd1;
            // A divide by zero still spends its cycles but leaves HI/LO untouched.
            if ((cnt_r == 4'd1) && !dz_r) begin
                hi_nxt_s = temp_hi_r;
                lo_nxt_s = temp_lo_r;
            end else begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        end
    end

    // State registers with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= 4'd0;
            temp_hi_r <= 32'd0;
            temp_lo_r <= 32'd0;
            dz_r      <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            temp_hi_r <= temp_hi_nxt_s;
            temp_lo_r <= temp_lo_nxt_s;
            dz_r      <= dz_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= (cnt_nxt_s != 4'd0);
        end
    end

    assign busy     = busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign stall_md = md_use_D & (start | busy_r);

endmodule
